// File: rtl/data_mem_sized_if.sv
// Request/response bundle for the byte-addressable data memory.
// The bench drives the master side; the memory sits on the slave side.
interface data_mem_sized_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 memWrite;
    logic                 memRead;
    logic [2:0]           funct3;
    logic [31:0]          address;
    logic [31:0]          writeData;
    logic [31:0]          readData;
    logic                 readValid;
    logic                 accessErr;
    logic [ERR_CNT_W-1:0] errCount;

    modport master (
        output memWrite, memRead, funct3, address, writeData,
        input  readData, readValid, accessErr, errCount
    );

    modport slave (
        input  memWrite, memRead, funct3, address, writeData,
        output readData, readValid, accessErr, errCount
    );
endinterface

// File: rtl/data_mem_sized.sv
// Word-organised data memory with byte/half/word loads and stores, alignment
// checking, a registered 1-cycle load path and a saturating rejection counter.
module data_mem_sized #(
    parameter int ADDR_BITS = 10,
    parameter int ERR_CNT_W = 8
) (
    input logic             clk,
    input logic             reset,
    data_mem_sized_if.slave bus
);
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int NUM_LANES = 4;

    logic [ADDR_BITS-1:0]           idx;
    logic [1:0]                     ofs;
    logic                           aligned, st_ok, ld_ok, rej;
    logic [NUM_LANES-1:0]           lane_we;
    logic [NUM_LANES-1:0][7:0]      wlane;
    logic [NUM_LANES-1:0][7:0]      rword;
    logic [7:0]                     bsel;
    logic [15:0]                    hsel;
    logic [31:0]                    readData_d, readData_q;
    logic                           readValid_q, accessErr_q;
    logic [ERR_CNT_W-1:0]           errCount_q;
    logic                           unused_addr;

    assign idx         = bus.address[ADDR_BITS+1:2];
    assign ofs         = bus.address[1:0];
    // High address bits are intentionally dropped so accesses wrap.
    assign unused_addr = ^bus.address[31:ADDR_BITS+2];

    always_comb begin
        aligned = 1'b0;
        case (bus.funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~ofs[0];
            2'b10:   aligned = (ofs == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign st_ok = bus.memWrite & ~bus.memRead & aligned &
                   (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 || bus.funct3 == 3'b010);
    assign ld_ok = bus.memRead & ~bus.memWrite & aligned &
                   (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                    bus.funct3 == 3'b100 || bus.funct3 == 3'b101);
    assign rej   = (bus.memRead | bus.memWrite) & ~st_ok & ~ld_ok;

    // Store data is replicated across lanes; the lane enables pick what lands.
    always_comb begin
        lane_we = '0;
        wlane   = bus.writeData;
        case (bus.funct3[1:0])
            2'b00: begin
                wlane        = {4{bus.writeData[7:0]}};
                lane_we[ofs] = st_ok;
            end
            2'b01: begin
                wlane                   = {2{bus.writeData[15:0]}};
                lane_we[{ofs[1], 1'b0}] = st_ok;
                lane_we[{ofs[1], 1'b1}] = st_ok;
            end
            default: lane_we = {NUM_LANES{st_ok}};
        endcase
    end

    // Memory is never reset; only gated off while reset is held.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];

        always_ff @(posedge clk) begin
            if (!reset && lane_we[l])
                mem_q[idx] <= wlane[l];
        end

        assign rword[l] = mem_q[idx];
    end

    assign bsel = rword[ofs];
    assign hsel = ofs[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};

    always_comb begin
        readData_d = rword;
        case (bus.funct3)
            3'b000:  readData_d = {{24{bsel[7]}}, bsel};
            3'b001:  readData_d = {{16{hsel[15]}}, hsel};
            3'b100:  readData_d = {24'h0, bsel};
            3'b101:  readData_d = {16'h0, hsel};
            default: readData_d = rword;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData_q  <= '0;
            readValid_q <= 1'b0;
            accessErr_q <= 1'b0;
            errCount_q  <= '0;
        end else begin
            readValid_q <= ld_ok;
            accessErr_q <= rej;
            if (ld_ok)
                readData_q <= readData_d;
            if (rej && errCount_q != {ERR_CNT_W{1'b1}})
                errCount_q <= errCount_q + 1'b1;
        end
    end

    assign bus.readData  = readData_q;
    assign bus.readValid = readValid_q;
    assign bus.accessErr = accessErr_q;
    assign bus.errCount  = errCount_q;
endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_BITS, 10, word-address width; depth = 2^ADDR_BITS 32-bit words.
- ERR_CNT_W, 8, width of the saturating error counter.

REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memWrite  input  1  store request this cycle.
- memRead  input  1  load request this cycle.
- funct3  input  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- address  input  32  byte address.
- writeData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- readData  output  32  load result, sign/zero-extended, registered.
- readValid  output  1  1-cycle pulse; readData is valid.
- accessErr  output  1  1-cycle pulse; previous request was rejected.
- errCount  output  ERR_CNT_W  saturating count of rejected requests.

Function
REQ-003 Word index SHALL be address[ADDR_BITS+1:2]; address bits above ADDR_BITS+1 SHALL be ignored, so accesses wrap modulo depth.
REQ-004 Alignment SHALL be checked as follows: half requires address[0]=0; word requires address[1:0]=00; byte is always aligned.
REQ-005 A store SHALL be accepted when memWrite=1, memRead=0, funct3 is a legal store code (000/001/010), and the access is aligned.
REQ-006 An accepted store SHALL write only the addressed lanes at the rising edge:
- byte: lane address[1:0] gets writeData[7:0].
- half: lanes {address[1],0} and {address[1],1} get writeData[15:0], little-endian.
- word: all 4 lanes get writeData.
- Unaddressed bytes SHALL be unchanged.
REQ-007 A load SHALL be accepted when memRead=1, memWrite=0, funct3 is a legal load code, and the access is aligned.
REQ-008 An accepted load SHALL have 1-cycle latency: readValid=1 and readData set in the cycle after the request edge.
REQ-009 Load extension SHALL follow funct3: byte/half sign-extend for 000/001, zero-extend for 100/101; word is returned unmodified.
REQ-010 When readValid=0, readData SHALL hold its last value.
REQ-011 A rejected request SHALL make no memory update and SHALL produce readValid=0 and accessErr=1 in the next cycle. A request is rejected when it is any of:
- memRead and memWrite both 1;
- an illegal funct3 for the operation (011, 110, 111, or store with 100/101);
- a misaligned access.
REQ-012 errCount SHALL increment by 1 on each rejection and saturate at 2^ERR_CNT_W-1.
REQ-013 A load issued the cycle after a store to the same word SHALL return the post-store data, with no stale read.
REQ-014 Back-to-back loads SHALL be accepted every cycle, producing one readValid pulse per load.
REQ-015 When memRead=memWrite=0 there SHALL be no memory change, readValid=0 and accessErr=0.

Reset
REQ-016 On reset assertion, independent of clk, the block SHALL force readData=0, readValid=0, accessErr=0 and errCount=0.
REQ-017 Reset SHALL NOT modify memory contents.
REQ-018 A load in flight when reset asserts SHALL be discarded, with no readValid after reset release.
REQ-019 Requests SHALL be ignored while reset=1.
REQ-020 The first rising edge after reset deassertion SHALL accept requests normally.

Verification
REQ-021 The bench SHALL cover word store then load: SW 0xAABBCCDD @0x0, then LW @0x0 -> next cycle readValid=1, readData=0xAABBCCDD.
REQ-022 The bench SHALL cover a byte store with sign and zero extension:
- Sequence: SW 0x11223344 @0x4, then SB 0x80 @0x6.
- Result: LW @0x4 -> 0x11803344.
- Result: LB @0x6 -> 0xFFFFFF80.
- Result: LBU @0x6 -> 0x00000080.
REQ-023 The bench SHALL cover half extension: SH 0x8001 @0x8, then LH @0x8 -> 0xFFFF8001; LHU @0x8 -> 0x00008001.
REQ-024 The bench SHALL cover rejections:
- LW @0x2: accessErr=1, readValid=0, errCount=1.
- memRead=memWrite=1: errCount=2, memory unchanged.
- funct3=011: errCount=3.
REQ-025 The bench SHALL cover wrap and boundary with ADDR_BITS=10: SW 0xDEADBEEF @0xFFC, then LW @0x1FFC -> 0xDEADBEEF.
REQ-026 The bench SHALL cover mid-operation reset: issue LW, assert reset before the next edge -> readValid stays 0, errCount=0; after release LW of the same address returns the pre-reset contents.
